// File: rtl/elevator_call_register.sv
// Pending-call register for an elevator car: per-floor set/clear bits plus summary flags.
// Optional macro CALL_DEBOUNCE_EN requires a press to be seen on two consecutive edges.
module elevator_call_register #(
    parameter int FLOORS = 8,
    parameter int FLW    = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FLOORS-1:0] in,
    input  logic [FLOORS-1:0] clr,
    input  logic [FLW-1:0]    cur_floor,
    output logic [FLOORS-1:0] out,
    output logic              flag,
    output logic [FLW:0]      count,
    output logic              any_above,
    output logic              any_below,
    output logic              at_floor
);

    logic [FLOORS-1:0] qual;

`ifdef CALL_DEBOUNCE_EN
    logic [FLOORS-1:0] in_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            in_prev <= '0;
        end else begin
            in_prev <= in;
        end
    end

    assign qual = in & in_prev;
`else
    assign qual = in;
`endif

    // Clear dominates a simultaneous press on the same floor.
    always_ff @(posedge clk) begin
        if (reset) begin
            out <= '0;
        end else begin
            out <= (out | qual) & ~clr;
        end
    end

    int cf;

    always_comb begin
        count     = '0;
        any_above = 1'b0;
        any_below = 1'b0;
        at_floor  = 1'b0;
        cf        = int'(cur_floor);
        for (int i = 0; i < FLOORS; i++) begin
            count = count + (FLW+1)'(out[i]);
            if (out[i] && (i > cf)) any_above = 1'b1;
            if (out[i] && (i < cf)) any_below = 1'b1;
            if (out[i] && (i == cf)) at_floor = 1'b1;
        end
    end

    assign flag = |out;

endmodule

// File: tb/tb_elevator_call_register.sv
// Directed self-checking bench for elevator_call_register (FLOORS=8, FLW=4).
// Honours CALL_DEBOUNCE_EN by holding presses for two edges when it is defined.
module tb_elevator_call_register;

    localparam int FLOORS = 8;
    localparam int FLW    = 4;
`ifdef CALL_DEBOUNCE_EN
    localparam int PRESS = 2;
`else
    localparam int PRESS = 1;
`endif

    logic              clk;
    logic              reset;
    logic [FLOORS-1:0] in;
    logic [FLOORS-1:0] clr;
    logic [FLW-1:0]    cur_floor;
    logic [FLOORS-1:0] out;
    logic              flag;
    logic [FLW:0]      count;
    logic              any_above;
    logic              any_below;
    logic              at_floor;

    int checks;
    int errors;

    elevator_call_register #(.FLOORS(FLOORS), .FLW(FLW)) dut (
        .clk(clk),
        .reset(reset),
        .in(in),
        .clr(clr),
        .cur_floor(cur_floor),
        .out(out),
        .flag(flag),
        .count(count),
        .any_above(any_above),
        .any_below(any_below),
        .at_floor(at_floor)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drive in/clr, take one rising edge, then settle 1ns past it.
    task automatic applyStimulus(input logic [FLOORS-1:0] vin, input logic [FLOORS-1:0] vclr);
        in  = vin;
        clr = vclr;
        @(posedge clk);
        #1;
    endtask

    task automatic pressCalls(input logic [FLOORS-1:0] v);
        for (int k = 0; k < PRESS; k++) applyStimulus(v, '0);
        in = '0;
    endtask

    task automatic checkAll(input string tag, input logic [7:0] eo, input logic ef,
                            input logic [4:0] ec, input logic ea, input logic eb, input logic eat);
        checkOutput({tag, ".out"}, 32'(out), 32'(eo));
        checkOutput({tag, ".flag"}, 32'(flag), 32'(ef));
        checkOutput({tag, ".count"}, 32'(count), 32'(ec));
        checkOutput({tag, ".above"}, 32'(any_above), 32'(ea));
        checkOutput({tag, ".below"}, 32'(any_below), 32'(eb));
        checkOutput({tag, ".at"}, 32'(at_floor), 32'(eat));
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        in        = '0;
        clr       = '0;
        cur_floor = '0;

        applyStimulus('0, '0);
        applyStimulus('0, '0);
        checkAll("reset", 8'h00, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);

        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            applyStimulus('0, '0);
            checkAll("idle", 8'h00, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        end

        // Calls at floors 0 and 5 seen from several car positions.
        cur_floor = 4'd3;
        pressCalls(8'b0010_0001);
        checkAll("two_calls_f3", 8'h21, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0);
        cur_floor = 4'd5; #1;
        checkAll("two_calls_f5", 8'h21, 1'b1, 5'd2, 1'b0, 1'b1, 1'b1);
        cur_floor = 4'd0; #1;
        checkAll("two_calls_f0", 8'h21, 1'b1, 5'd2, 1'b1, 1'b0, 1'b1);
        cur_floor = 4'd7; #1;
        checkAll("two_calls_f7", 8'h21, 1'b1, 5'd2, 1'b0, 1'b1, 1'b0);
        applyStimulus('0, 8'hFF);
        checkOutput("clear_all", 32'(out), 32'h00);

        // Press and clear together on floor 3: clear wins, then held press re-sets.
        cur_floor = 4'd3;
        pressCalls(8'h08);
        checkOutput("set_f3", 32'(out), 32'h08);
        applyStimulus(8'h08, 8'h08);
        checkOutput("press_clr_same", 32'(out), 32'h00);
        applyStimulus(8'h08, 8'h00);
        checkOutput("reset_by_held", 32'(out), 32'h08);
        applyStimulus(8'h08, 8'h00);
        checkOutput("press_on_set", 32'(out), 32'h08);
        applyStimulus(8'h00, 8'h01);
        checkOutput("clr_on_clear", 32'(out), 32'h08);
        applyStimulus(8'h00, 8'h08);
        checkOutput("clear_f3", 32'(out), 32'h00);

        // All floors called, then cleared one per cycle.
        pressCalls(8'hFF);
        checkOutput("all_count", 32'(count), 32'd8);
        checkOutput("all_flag", 32'(flag), 32'd1);
        for (int i = 0; i < FLOORS; i++) begin
            applyStimulus('0, 8'(1 << i));
            checkOutput("step_count", 32'(count), 32'(7 - i));
            checkOutput("step_flag", 32'(flag), 32'(i != 7));
        end
        clr = '0;

`ifdef CALL_DEBOUNCE_EN
        applyStimulus(8'h04, '0);
        applyStimulus(8'h00, '0);
        checkOutput("pulse1_ignored", 32'(out), 32'h00);
        applyStimulus(8'h04, '0);
        checkOutput("pulse2_first", 32'(out), 32'h00);
        applyStimulus(8'h04, '0);
        checkOutput("pulse2_second", 32'(out), 32'h04);
`else
        applyStimulus(8'h04, '0);
        checkOutput("pulse1_sets", 32'(out), 32'h04);
        applyStimulus(8'h00, '0);
        checkOutput("pulse1_holds", 32'(out), 32'h04);
`endif
        applyStimulus('0, 8'hFF);
        checkOutput("clear_pulse", 32'(out), 32'h00);

        // Out-of-range car position, then reset overriding a full press.
        pressCalls(8'h81);
        cur_floor = 4'd9; #1;
        checkAll("oor_f9", 8'h81, 1'b1, 5'd2, 1'b0, 1'b1, 1'b0);
        reset = 1'b1;
        applyStimulus(8'hFF, 8'h00);
        checkAll("reset_mid", 8'h00, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        applyStimulus(8'h00, 8'h00);
        checkAll("after_reset", 8'h00, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
